// File: rtl/fetch_pkg.sv
// Shared fetch-stage definitions: reset PC, nop word, queue entry and FSM state types.
package fetch_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
  localparam logic [31:0] NOP_WORD         = 32'h0000_0000;

  // One buffered instruction together with the PC it was fetched from.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  // RUN: normal fetch. PEND: delay slot still to be requested, target parked in pend_pc.
  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_PEND = 1'b1
  } fetch_state_t;

  // Instruction addresses are word aligned; the low two bits of a target are ignored.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of fetched instructions with a "keep only the head" flush.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  fetch_entry_t               push_entry,
  input  logic                       pop,
  input  logic                       flush_keep_head,
  output fetch_entry_t               head,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  fetch_entry_t  mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q,  count_d;
  logic          do_push, do_pop, full;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  // Pointer/count update; a flush on a non-empty queue keeps only the head and swallows any same-cycle push.
  always_comb begin
    // NOTE: every always_comb output gets a default first, otherwise a missed branch infers a latch.
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    do_push  = 1'b0;
    do_pop   = pop && !empty;
    if (flush_keep_head && !empty) begin
      rd_ptr_d = do_pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
      wr_ptr_d = rd_ptr_q + PW'(1);
      count_d  = do_pop ? '0 : CW'(1);
    end else begin
      do_push = push && (!full || do_pop);
      if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Control state register, cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage write.
  always_ff @(posedge clk) begin
    // NOTE: storage is deliberately not reset; count_q alone decides which entries are meaningful.
    if (do_push) mem_q[wr_ptr_q] <= push_entry;
  end

endmodule

// File: rtl/fetch_unit.sv
// IF stage: owns the fetch PC, talks to instruction memory and feeds the IF/ID register,
// honouring stalls and D-stage redirects with one delay slot.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = RESET_PC_DEFAULT,
  parameter int          QUEUE_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        im_req_valid,
  input  logic        im_req_ready,
  output logic [31:0] im_req_addr,
  input  logic        im_resp_valid,
  input  logic [31:0] im_resp_data,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] F_Instruction,
  output logic [31:0] F_PC,
  output logic        F_valid
);

  localparam int CW = $clog2(QUEUE_DEPTH) + 1;

  logic [31:0]  fpc_q, fpc_d;
  logic [31:0]  req_pc_q, req_pc_d;
  logic [31:0]  pend_pc_q, pend_pc_d;
  logic         outstanding_q, outstanding_d;
  logic         discard_q, discard_d;
  fetch_state_t state_q, state_d;

  fetch_entry_t q_head;
  logic [CW-1:0] q_count;
  logic         q_empty, q_push, q_pop, q_flush;
  logic         req_fire, resp_fire;
  logic [31:0]  target;

  // Only one request in flight; a same-cycle pop does not free a slot.
  assign im_req_valid = !reset && !outstanding_q && (q_count < CW'(QUEUE_DEPTH));
  assign im_req_addr  = fpc_q;
  assign req_fire     = im_req_valid && im_req_ready;
  assign resp_fire    = im_resp_valid && outstanding_q;
  assign q_pop        = !q_empty && !stall;

  assign F_valid       = !q_empty;
  assign F_Instruction = q_empty ? NOP_WORD : q_head.instr;
  assign F_PC          = q_empty ? 32'h0 : q_head.pc;

  fetch_queue #(.DEPTH(QUEUE_DEPTH)) u_queue (
    .clk             (clk),
    .reset           (reset),
    .push            (q_push),
    .push_entry      ('{pc: req_pc_q, instr: im_resp_data}),
    .pop             (q_pop),
    .flush_keep_head (q_flush),
    .head            (q_head),
    .count           (q_count),
    .empty           (q_empty)
  );

  // Next-state logic: response first, then request handshake, then redirect overrides.
  always_comb begin
    fpc_d         = fpc_q;
    req_pc_d      = req_pc_q;
    pend_pc_d     = pend_pc_q;
    outstanding_d = outstanding_q;
    discard_d     = discard_q;
    state_d       = state_q;
    q_push        = 1'b0;
    q_flush       = 1'b0;
    target        = word_align(redirect_pc);

    if (resp_fire) begin
      outstanding_d = 1'b0;
      if (discard_q) discard_d = 1'b0;
      else           q_push    = 1'b1;
    end

    if (req_fire) begin
      outstanding_d = 1'b1;
      req_pc_d      = fpc_q;
      if (state_q == ST_PEND) begin
        fpc_d   = pend_pc_q;
        state_d = ST_RUN;
      end else begin
        fpc_d = fpc_q + 32'd4;
      end
    end

    if (redirect_valid) begin
      if (state_q == ST_PEND) begin
        // Pipeline should never do this; the newer target simply wins.
        pend_pc_d = target;
        if (req_fire) fpc_d = target;
      end else if (!q_empty) begin
        // Head is the delay slot: everything younger, including a request accepted now, dies.
        q_flush   = 1'b1;
        discard_d = outstanding_d;
        fpc_d     = target;
      end else if (outstanding_q || req_fire) begin
        // The in-flight or just-accepted request is the delay slot.
        fpc_d = target;
      end else begin
        // Delay slot not yet requested: park the target until it is.
        pend_pc_d = target;
        state_d   = ST_PEND;
      end
    end
  end

  // Fetch control registers, cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fpc_q         <= RESET_PC;
      req_pc_q      <= 32'h0;
      pend_pc_q     <= 32'h0;
      outstanding_q <= 1'b0;
      discard_q     <= 1'b0;
      state_q       <= ST_RUN;
    end else begin
      fpc_q         <= fpc_d;
      req_pc_q      <= req_pc_d;
      pend_pc_q     <= pend_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      state_q       <= state_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: tests queue expected PCs, a monitor checks each consumed head,
// and a behavioural instruction memory answers requests after a programmable latency.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        im_req_valid, im_req_ready;
  logic [31:0] im_req_addr;
  logic        im_resp_valid;
  logic [31:0] im_resp_data;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic [31:0] F_Instruction, F_PC;
  logic        F_valid;

  logic        ready_en = 1'b1;
  logic        spur_resp = 1'b0;
  logic        mem_resp_valid = 1'b0;
  logic [31:0] mem_resp_data = 32'h0;
  int          lat = 1;

  logic [31:0] exp_q [$];
  int          vectors = 0;
  int          errors = 0;

  assign im_req_ready  = ready_en;
  assign im_resp_valid = mem_resp_valid | spur_resp;
  assign im_resp_data  = spur_resp ? 32'hDEAD_BEEF : mem_resp_data;

  fetch_unit #(.RESET_PC(32'h0000_3000), .QUEUE_DEPTH(2)) dut (
    .clk            (clk),
    .reset          (reset),
    .im_req_valid   (im_req_valid),
    .im_req_ready   (im_req_ready),
    .im_req_addr    (im_req_addr),
    .im_resp_valid  (im_resp_valid),
    .im_resp_data   (im_resp_data),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .F_Instruction  (F_Instruction),
    .F_PC           (F_PC),
    .F_valid        (F_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h2000_0000;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    vectors++;
    errors++;
    $display("FAIL %s: timed out, %0d expected entries left", name, exp_q.size());
  endtask

  // Drive slot: 1 time unit after the falling edge.
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic reset_dut();
    step();
    reset = 1'b1;
    stall = 1'b0;
    redirect_valid = 1'b0;
    ready_en = 1'b1;
    spur_resp = 1'b0;
    lat = 1;
    repeat (2) step();
    exp_q.delete();
    reset = 1'b0;
  endtask

  task automatic wait_head(input logic [31:0] pc, input int budget);
    for (int i = 0; i < budget; i++) begin
      step();
      if (F_valid && F_PC == pc) return;
    end
    timeout_fail("wait_head");
  endtask

  task automatic wait_drain(input string name, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() == 0) return;
      step();
    end
    timeout_fail(name);
  endtask

  // Instruction memory: one outstanding request, answered lat cycles after acceptance.
  initial begin
    bit          inflight;
    logic [31:0] addr;
    int          cyc, due;
    inflight = 1'b0;
    addr = 32'h0;
    cyc = 0;
    due = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (inflight && cyc == due) begin
        mem_resp_valid = 1'b1;
        mem_resp_data  = mem_word(addr);
        inflight       = 1'b0;
      end else begin
        mem_resp_valid = 1'b0;
      end
      #3;
      if (reset) begin
        inflight = 1'b0;
      end else if (im_req_valid && im_req_ready) begin
        inflight = 1'b1;
        addr     = im_req_addr;
        due      = cyc + lat;
      end
    end
  end

  // Monitor: every head that IF/ID consumes is compared against the scoreboard.
  initial begin
    logic [31:0] pc;
    forever begin
      @(negedge clk);
      #2;
      if (!reset && F_valid && !stall && exp_q.size() > 0) begin
        pc = exp_q.pop_front();
        check("head_pc", F_PC, pc);
        check("head_instr", F_Instruction, mem_word(pc));
      end
    end
  end

  initial begin
    #1 reset = 1'b1;

    // Reset values and streaming with a single-cycle memory.
    repeat (2) step();
    check("rst_req_valid", {31'b0, im_req_valid}, 32'd0);
    check("rst_f_valid", {31'b0, F_valid}, 32'd0);
    check("rst_f_instr", F_Instruction, 32'h0);
    check("rst_f_pc", F_PC, 32'h0);
    reset = 1'b0;
    exp_q = '{32'h3000, 32'h3004, 32'h3008};
    #1;
    check("first_req_valid", {31'b0, im_req_valid}, 32'd1);
    check("first_req_addr", im_req_addr, 32'h3000);
    wait_drain("stream", 40);

    // Stall back-pressure: queue fills, requests stop, head holds.
    reset_dut();
    exp_q = '{32'h3000, 32'h3004, 32'h3008};
    wait_head(32'h3000, 20);
    stall = 1'b1;
    repeat (5) step();
    check("stall_req_valid", {31'b0, im_req_valid}, 32'd0);
    check("stall_f_valid", {31'b0, F_valid}, 32'd1);
    check("stall_f_pc", F_PC, 32'h3000);
    stall = 1'b0;
    wait_drain("stall_release", 40);

    // Case A: head 0x3004 popped while 0x3008 is accepted in the same cycle.
    reset_dut();
    exp_q = '{32'h3000, 32'h3004, 32'h3100, 32'h3104};
    wait_head(32'h3004, 20);
    redirect_valid = 1'b1;
    redirect_pc = 32'h3100;
    step();
    redirect_valid = 1'b0;
    wait_drain("case_a_pop", 40);

    // Case A: head 0x3004 with 0x3008 queued behind it, under stall.
    reset_dut();
    stall = 1'b1;
    exp_q = '{32'h3000, 32'h3004, 32'h3100, 32'h3104};
    repeat (6) step();
    stall = 1'b0;
    step();
    stall = 1'b1;
    repeat (3) step();
    check("case_a_full_req_valid", {31'b0, im_req_valid}, 32'd0);
    check("case_a_full_head", F_PC, 32'h3004);
    redirect_valid = 1'b1;
    redirect_pc = 32'h3100;
    step();
    redirect_valid = 1'b0;
    stall = 1'b0;
    wait_drain("case_a_full", 40);

    // Case B: queue empty, 0x3008 in flight with a 3-cycle memory.
    reset_dut();
    lat = 3;
    exp_q = '{32'h3000, 32'h3004, 32'h3008, 32'h4000, 32'h4004};
    wait_head(32'h3004, 30);
    step();
    check("case_b_outstanding", {31'b0, im_req_valid}, 32'd0);
    redirect_valid = 1'b1;
    redirect_pc = 32'h4000;
    step();
    redirect_valid = 1'b0;
    wait_drain("case_b", 60);

    // Case D: delay slot 0x3008 not yet requested; low target bits are ignored.
    reset_dut();
    lat = 3;
    exp_q = '{32'h3000, 32'h3004, 32'h3008, 32'h4000, 32'h4004};
    wait_head(32'h3004, 30);
    ready_en = 1'b0;
    step();
    check("case_d_fpc", im_req_addr, 32'h3008);
    redirect_valid = 1'b1;
    redirect_pc = 32'h4002;
    step();
    redirect_valid = 1'b0;
    ready_en = 1'b1;
    check("case_d_pend_addr", im_req_addr, 32'h3008);
    check("case_d_pend_valid", {31'b0, im_req_valid}, 32'd1);
    wait_drain("case_d", 60);

    // Slow memory: address held, nothing at the head, spurious response ignored.
    reset_dut();
    ready_en = 1'b0;
    exp_q = '{32'h3000, 32'h3004};
    for (int i = 0; i < 4; i++) begin
      step();
      check("slow_addr", im_req_addr, 32'h3000);
      check("slow_valid", {31'b0, im_req_valid}, 32'd1);
      check("slow_f_valid", {31'b0, F_valid}, 32'd0);
      check("slow_f_instr", F_Instruction, 32'h0);
      spur_resp = (i == 1);
    end
    step();
    spur_resp = 1'b0;
    check("spurious_ignored", {31'b0, F_valid}, 32'd0);
    ready_en = 1'b1;
    wait_drain("slow", 40);

    // Reset mid-operation: one entry queued and 0x3004 outstanding.
    reset_dut();
    lat = 3;
    stall = 1'b1;
    repeat (5) step();
    check("mid_pre_f_valid", {31'b0, F_valid}, 32'd1);
    reset = 1'b1;
    #1;
    check("mid_rst_f_valid", {31'b0, F_valid}, 32'd0);
    check("mid_rst_f_pc", F_PC, 32'h0);
    check("mid_rst_f_instr", F_Instruction, 32'h0);
    check("mid_rst_req_valid", {31'b0, im_req_valid}, 32'd0);
    repeat (2) step();
    reset = 1'b0;
    stall = 1'b0;
    lat = 1;
    spur_resp = 1'b1;
    exp_q = '{32'h3000, 32'h3004};
    #1;
    check("mid_first_addr", im_req_addr, 32'h3000);
    check("mid_first_valid", {31'b0, im_req_valid}, 32'd1);
    step();
    spur_resp = 1'b0;
    wait_drain("mid_reset", 40);

    step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  // Absolute safety net so the run can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d errors so far", errors);
    $fatal(1, "watchdog expired");
  end

endmodule
